keypad_scanner: RTL

Scans a 4x4 active-low matrix keypad, debounces, and produces the digit/load stream that the password entry register consumes: a 4-bit key code on `one_digit` and a `load` level held for the whole debounced press. It sits between the board keypad pins and `password_reg` in `system_logic`, replacing the switch-plus-button entry path. It also provides `key_strobe`, a single-cycle pulse per accepted press, for event counting in the system logic.

---
 rtl/keypad_scanner.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce, producing the digit/load
// stream for the password entry register plus a one-cycle strobe per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] one_digit,
    output logic       load,
    output logic       key_strobe
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_meta_q, row_meta_d;
    logic [3:0]       row_sync_q, row_sync_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       pattern_q, pattern_d;
    logic [3:0]       digit_q, digit_d;
    logic             load_q, load_d;
    logic             strobe_q, strobe_d;

    logic             sample_tick;
    logic             all_high;
    logic             one_low;
    logic [3:0]       row_low;
    logic [1:0]       row_idx;
    logic [3:0]       key_code;
    logic [CNT_W-1:0] cnt_inc;

    assign sample_tick = (div_q == DIV_LAST);
    assign row_low     = ~row_sync_q;
    assign all_high    = (row_sync_q == 4'b1111);
    // Exactly one row low: non-zero and a power of two.
    assign one_low     = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    assign cnt_inc     = cnt_q + CNT_W'(1);

    always_comb begin
        row_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!pattern_q[i]) begin
                row_idx = 2'(i);
            end
        end
    end

    always_comb begin
        key_code = 4'd0;
        case ({row_idx, col_q})
            4'b00_00: key_code = 4'd1;
            4'b00_01: key_code = 4'd2;
            4'b00_10: key_code = 4'd3;
            4'b00_11: key_code = 4'd10;
            4'b01_00: key_code = 4'd4;
            4'b01_01: key_code = 4'd5;
            4'b01_10: key_code = 4'd6;
            4'b01_11: key_code = 4'd11;
            4'b10_00: key_code = 4'd7;
            4'b10_01: key_code = 4'd8;
            4'b10_10: key_code = 4'd9;
            4'b10_11: key_code = 4'd12;
            4'b11_00: key_code = 4'd14;
            4'b11_01: key_code = 4'd0;
            4'b11_10: key_code = 4'd15;
            4'b11_11: key_code = 4'd13;
            default:  key_code = 4'd0;
        endcase
    end

    always_comb begin
        row_meta_d = row_in;
        row_sync_d = row_meta_q;
        state_d    = state_q;
        div_d      = sample_tick ? '0 : div_q + DIV_W'(1);
        cnt_d      = cnt_q;
        col_d      = col_q;
        pattern_d  = pattern_q;
        digit_d    = digit_q;
        load_d     = load_q;
        strobe_d   = 1'b0;

        if (sample_tick) begin
            unique case (state_q)
                SCAN: begin
                    if (one_low) begin
                        pattern_d = row_sync_q;
                        cnt_d     = CNT_W'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_sync_q == pattern_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            cnt_d    = '0;
                            state_d  = HELD;
                            digit_d  = key_code;
                            load_d   = 1'b1;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                HELD: begin
                    if (all_high) begin
                        cnt_d   = CNT_W'(1);
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            cnt_d   = '0;
                            load_d  = 1'b0;
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end
                    end else begin
                        // A bounce low during release keeps the key held, no new strobe.
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            state_q    <= SCAN;
            div_q      <= '0;
            cnt_q      <= '0;
            col_q      <= 2'd0;
            pattern_q  <= 4'b1111;
            digit_q    <= 4'd0;
            load_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            pattern_q  <= pattern_d;
            digit_q    <= digit_d;
            load_q     <= load_d;
            strobe_q   <= strobe_d;
        end
    end

    assign col_out    = ~(4'b0001 << col_q);
    assign one_digit  = digit_q;
    assign load       = load_q;
    assign key_strobe = strobe_q;
endmodule
